fp_posit_mul_array: RTL

Multi-lane successor to the single-lane FP×posit multiplier. One FP activation (sign/exponent/mantissa) is broadcast to LANES independent bit-serial posit weight streams. Precision and exponent size are parametrised, and the runtime precision is selectable. Each lane decodes its posit weight (two's-complement, regime, exponent, fraction) and produces an unnormalised sign/scale/mantissa product. This output feeds the downstream accumulator.

---
 rtl/fp_posit_mul_array.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_posit_mul_array.sv
// Multi-lane FP activation x bit-serial posit weight multiplier.
// One activation is broadcast to LANES serial posit streams; each lane yields an unnormalised sign/scale/mantissa product.
module fp_posit_mul_array #(
  parameter int ACT_WIDTH = 16,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10,
  parameter int LANES     = 4,
  parameter int MAX_PREC  = 8,
  parameter int ES        = 1,
  parameter int SCALE_W   = 8,
  localparam int FRAC_W   = MAX_PREC - 3,
  localparam int PROD_W   = MAN_WIDTH + FRAC_W + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ACT_WIDTH-1:0]       act,
  input  logic [LANES-1:0]           w,
  input  logic                       valid,
  input  logic                       set,
  input  logic [3:0]                 precision,
  output logic [LANES-1:0]           sign_out,
  output logic [LANES*SCALE_W-1:0]   scale_out,
  output logic [LANES*PROD_W-1:0]    man_out,
  output logic [LANES-1:0]           zero_out,
  output logic [LANES-1:0]           nar_out,
  output logic                       busy,
  output logic                       done
);

  localparam int IW = 16;
  localparam logic [3:0] PMAX = 4'(MAX_PREC);
  localparam logic signed [IW-1:0] BIAS_S = IW'((2 ** (EXP_WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0] ONE_S  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [MAX_PREC-1:0]  ONE_P  = {{(MAX_PREC-1){1'b0}}, 1'b1};
  localparam logic [MAX_PREC-1:0]  NAR_P  = {1'b1, {(MAX_PREC-1){1'b0}}};

  logic [3:0]                      prec_q, prec_d;
  logic [3:0]                      cnt_q, cnt_d;
  logic                            busy_q, busy_d;
  logic [ACT_WIDTH-1:0]            act_q, act_d;
  logic [LANES-1:0][MAX_PREC-1:0]  sr_q, sr_d;
  logic                            dv_q, dv_d;
  logic [LANES-1:0][MAX_PREC-1:0]  dw_q, dw_d;
  logic [ACT_WIDTH-1:0]            da_q, da_d;
  logic [3:0]                      dp_q, dp_d;

  logic [LANES-1:0]                sign_q, sign_d, zero_q, zero_d, nar_q, nar_d;
  logic [LANES*SCALE_W-1:0]        scale_q, scale_d;
  logic [LANES*PROD_W-1:0]         man_q, man_d;
  logic                            done_q, done_d;

  logic [LANES-1:0]                lane_sign_s, lane_zero_s, lane_nar_s;
  logic [LANES*SCALE_W-1:0]        lane_scale_s;
  logic [LANES*PROD_W-1:0]         lane_man_s;

  // Serial capture: precision load, bit counter, shift registers and hand-off to decode.
  always_comb begin
    prec_d = prec_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    sr_d   = sr_q;
    dv_d   = 1'b0;
    dw_d   = dw_q;
    da_d   = da_q;
    dp_d   = dp_q;
    if (set && (cnt_q == 4'd0)) begin
      if (precision < 4'd3) begin
        prec_d = 4'd3;
      end else if (precision > PMAX) begin
        prec_d = PMAX;
      end else begin
        prec_d = precision;
      end
    end else begin
      prec_d = prec_q;
    end
    if (valid) begin
      for (int i = 0; i < LANES; i++) begin
        sr_d[i] = MAX_PREC'({sr_q[i], w[i]});
      end
      if (cnt_q == 4'd0) begin
        act_d = act;
      end else begin
        act_d = act_q;
      end
      if (cnt_q == prec_q - 4'd1) begin
        cnt_d = 4'd0;
        dv_d  = 1'b1;
        dw_d  = sr_d;
        da_d  = act_q;
        dp_d  = prec_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
    busy_d = (cnt_d != 4'd0);
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [MAX_PREC-1:0]    aligned, mag, rest, e_w;
    logic [FRAC_W-1:0]      frac;
    logic                   p_zero, p_nar, p_sign, rbit, stop;
    logic [3:0]             r, consumed;
    logic signed [IW-1:0]   r_ext, k, pscale, scale, a_exp_ext;
    logic                   a_sign, a_zero, a_nar, l_zero, l_nar;
    logic [EXP_WIDTH-1:0]   a_exp;
    logic [MAN_WIDTH-1:0]   a_man;
    logic                   l_sign;
    logic [SCALE_W-1:0]     l_scale;
    logic [PROD_W-1:0]      l_man;

    // Posit decode of one lane's word followed by the product with the held activation.
    always_comb begin
      // Left-align the P-bit word so every lane/precision decodes from the MSB down.
      aligned = dw_q[gi] << (PMAX - dp_q);
      p_zero  = (aligned == '0);
      p_nar   = (aligned == NAR_P);
      p_sign  = aligned[MAX_PREC-1];
      if (p_sign) begin
        mag = ~aligned + ONE_P;
      end else begin
        mag = aligned;
      end
      rbit = mag[MAX_PREC-2];
      r    = 4'd0;
      stop = 1'b0;
      for (int j = MAX_PREC - 2; j >= 0; j--) begin
        if (!stop && (j >= MAX_PREC - int'(dp_q)) && (mag[j] == rbit)) begin
          r = r + 4'd1;
        end else begin
          stop = 1'b1;
        end
      end
      r_ext = $signed({{(IW-4){1'b0}}, r});
      if (rbit) begin
        k = r_ext - ONE_S;
      end else begin
        k = -r_ext;
      end
      consumed = 4'd1 + r + ((r < dp_q - 4'd1) ? 4'd1 : 4'd0);
      rest     = mag << consumed;
      e_w      = rest >> (MAX_PREC - ES);
      frac     = FRAC_W'(rest >> (MAX_PREC - ES - FRAC_W));
      pscale   = (k <<< ES) + $signed({{(IW-MAX_PREC){1'b0}}, e_w});

      a_sign    = da_q[ACT_WIDTH-1];
      a_exp     = da_q[ACT_WIDTH-2 -: EXP_WIDTH];
      a_man     = da_q[MAN_WIDTH-1:0];
      a_zero    = (a_exp == '0);
      a_nar     = &a_exp;
      a_exp_ext = $signed({{(IW-EXP_WIDTH){1'b0}}, a_exp});
      scale     = a_exp_ext - BIAS_S + pscale;

      l_nar  = a_nar | p_nar;
      l_zero = !l_nar && (a_zero || p_zero);
      if (l_nar || l_zero) begin
        l_sign  = 1'b0;
        l_scale = '0;
        l_man   = '0;
      end else begin
        l_sign  = a_sign ^ p_sign;
        l_scale = SCALE_W'(scale);
        l_man   = PROD_W'({1'b1, a_man}) * PROD_W'({1'b1, frac});
      end
    end

    assign lane_sign_s[gi]                     = l_sign;
    assign lane_zero_s[gi]                     = l_zero;
    assign lane_nar_s[gi]                      = l_nar;
    assign lane_scale_s[gi*SCALE_W +: SCALE_W] = l_scale;
    assign lane_man_s[gi*PROD_W +: PROD_W]     = l_man;
  end

  // Output stage: lane results register one cycle after the decode stage loads.
  always_comb begin
    done_d = dv_q;
    if (dv_q) begin
      sign_d  = lane_sign_s;
      zero_d  = lane_zero_s;
      nar_d   = lane_nar_s;
      scale_d = lane_scale_s;
      man_d   = lane_man_s;
    end else begin
      sign_d  = sign_q;
      zero_d  = zero_q;
      nar_d   = nar_q;
      scale_d = scale_q;
      man_d   = man_q;
    end
  end

  // State registers for capture, decode and output stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prec_q  <= PMAX;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      act_q   <= '0;
      sr_q    <= '0;
      dv_q    <= 1'b0;
      dw_q    <= '0;
      da_q    <= '0;
      dp_q    <= PMAX;
      sign_q  <= '0;
      zero_q  <= '0;
      nar_q   <= '0;
      scale_q <= '0;
      man_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      prec_q  <= prec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      act_q   <= act_d;
      sr_q    <= sr_d;
      dv_q    <= dv_d;
      dw_q    <= dw_d;
      da_q    <= da_d;
      dp_q    <= dp_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      nar_q   <= nar_d;
      scale_q <= scale_d;
      man_q   <= man_d;
      done_q  <= done_d;
    end
  end

  assign sign_out  = sign_q;
  assign zero_out  = zero_q;
  assign nar_out   = nar_q;
  assign scale_out = scale_q;
  assign man_out   = man_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
